// File: rtl/mux_pkg.sv
// Shared types for the mux_n_scan channel multiplexer (scan mode gated by
// MUX_N_SCAN_AUTO_SCAN_EN in the top).
package mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_n_scan_rr_pick.sv
// Combinational round-robin picker: first requesting channel strictly after
// `last`, wrapping modulo N_CH.
module rr_pick #(
   parameter int unsigned N_CH  = 8,
   parameter int unsigned SEL_W = 3
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic [N_CH-1:0] mask;

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      mask    = '0;
      // Walk from the farthest offset to the nearest so the nearest request wins.
      for (int unsigned off = N_CH; off >= 1; off--) begin
         mask = N_CH'(1) << ((32'(last) + off) % N_CH);
         if ((req & mask) != '0) begin
            gnt_any = 1'b1;
            gnt_idx = SEL_W'((32'(last) + off) % N_CH);
         end
      end
   end

endmodule

// File: rtl/mux_n_scan.sv
// N-channel mux into a one-entry output register; round-robin scan mode is
// compiled in only when MUX_N_SCAN_AUTO_SCAN_EN is defined.
module mux_n_scan
   import mux_pkg::*;
#(
   parameter int unsigned  N_CH  = 8,
   parameter int unsigned  W     = 8,
   localparam int unsigned SEL_W = sel_width(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH*W-1:0] in_data,
   input  logic [N_CH-1:0]   in_valid,
   output logic [N_CH-1:0]   in_ready,
   input  logic [SEL_W-1:0]  sel,
   input  logic              mode,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready
);

   state_e           state_q, state_d;
   logic [W-1:0]     data_q, data_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic             load, xfer;
   logic [SEL_W-1:0] pick;
   logic             pick_ok;
   logic [W-1:0]     pick_data;
   logic             pick_valid;

   assign load = (state_q == ST_EMPTY) || out_ready;

`ifdef MUX_N_SCAN_AUTO_SCAN_EN
   mode_e            mode_eff;
   logic [SEL_W-1:0] last_q, last_d;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;

   assign mode_eff = mode_e'(mode);

   rr_pick #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req     (in_valid),
      .last    (last_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      if (mode_eff == MODE_SCAN) begin
         pick    = gnt_idx;
         pick_ok = gnt_any;
      end else begin
         pick    = sel;
         pick_ok = (32'(sel) < N_CH);
      end
   end

   assign last_d = (xfer && (mode_eff == MODE_SCAN)) ? pick : last_q;

   // Reset to the top channel so the first scan search starts at channel 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= SEL_W'(N_CH - 1);
      end else begin
         last_q <= last_d;
      end
   end
`else
   logic unused_mode;

   assign unused_mode = mode;
   assign pick        = sel;
   assign pick_ok     = (32'(sel) < N_CH);
`endif

   always_comb begin
      pick_data  = '0;
      pick_valid = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (32'(pick) == i) begin
            pick_data  = in_data[i*W +: W];
            pick_valid = in_valid[i];
         end
      end
   end

   assign xfer = load && pick_ok && pick_valid;

   always_comb begin
      in_ready = '0;
      if (load && pick_ok && !reset) begin
         in_ready = N_CH'(1) << pick;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      if (xfer) begin
         state_d = ST_FULL;
         data_d  = pick_data;
         ch_d    = pick;
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_ch    = ch_q;

endmodule

// File: doc/mux_n_scan.md
MUX_N_SCAN -- requirements
Module: mux_n_scan

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of input channels (2..64).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL have derived localparam SEL_W = max(1, clog2(N_CH)), the select width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_data, input, N_CH*W, channel i occupying bits [i*W +: W].
REQ-007 SHALL have port in_valid, input, N_CH, per-channel data-valid.
REQ-008 SHALL have port in_ready, output, N_CH, per-channel accept strobe (one-hot or zero).
REQ-009 SHALL have port sel, input, SEL_W, manual channel select.
REQ-010 SHALL have port mode, input, 1, 0 = manual, 1 = round-robin scan.
REQ-011 SHALL have port out_data, output, W, registered selected data.
REQ-012 SHALL have port out_ch, output, SEL_W, channel index of out_data.
REQ-013 SHALL have port out_valid, output, 1, out_data holds an untaken word.
REQ-014 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-015 SHALL hold a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define load = EMPTY or (FULL and out_ready); a transfer occurs when load and in_valid[c] for the chosen channel c.
REQ-017 SHALL assert in_ready[c] combinationally only when load is true; in_ready is all-zero otherwise.
REQ-018 SHALL in manual mode choose c = sel; if sel >= N_CH, no channel is chosen and in_ready is zero.
REQ-019 SHALL in scan mode choose the first valid channel, searching upward from (last_grant+1) mod N_CH with wrap-around.
REQ-020 SHALL update last_grant only on a scan-mode transfer.
REQ-021 SHALL on a transfer register in_data[c] into out_data and c into out_ch, and be FULL next cycle (1-cycle latency).
REQ-022 SHALL go FULL->EMPTY when out_ready with no transfer, and FULL->FULL with new data on simultaneous drain and transfer (full throughput, one word per cycle).
REQ-023 SHALL hold out_data/out_ch stable while FULL and out_ready=0, regardless of sel, mode or in_* changes.
REQ-024 SHALL sample mode and sel every cycle; a change affects only the next transfer.

Reset
REQ-025 SHALL on reset force out_valid=0, out_data=0, out_ch=0, state EMPTY, and last_grant=N_CH-1 so that the first scan searches from channel 0.
REQ-026 SHALL drop an in-flight word when reset asserts mid-operation; in_ready SHALL be zero while reset is high.

Configuration
REQ-027 SHALL compile scan mode only when MUX_N_SCAN_AUTO_SCAN_EN is defined.
REQ-028 SHALL without MUX_N_SCAN_AUTO_SCAN_EN keep the mode port, ignore it (treat as 0), and omit the last_grant register and picker.

Structure
REQ-029 SHALL place the mode enum (MODE_MANUAL, MODE_SCAN) and state enum (ST_EMPTY, ST_FULL) in shared package mux_pkg.
REQ-030 SHALL implement the round-robin search as combinational sub-module rr_pick (inputs req[N_CH] and last[SEL_W]; outputs gnt_idx and gnt_any).

Verification
REQ-031 SHALL verify manual mode, N_CH=8, W=8: sel=5, in_valid=8'h20, ch5=8'hA5, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=8'hA5, out_ch=5.
REQ-032 SHALL verify scan after reset: in_valid=8'hFF held, out_ready=1 -> out_ch sequence 0,1,...,7,0 on consecutive cycles.
REQ-033 SHALL verify backpressure: FULL with out_data=8'h11, out_ready=0 for 5 cycles while sel/in_data change -> out_data stays 8'h11 and in_ready=0.
REQ-034 SHALL verify scan wrap-around: last grant=6, in_valid=8'h09 -> next grant is ch0, then ch3.
REQ-035 SHALL verify an out-of-range sel with N_CH=6: sel=7 -> in_ready=0 and out_valid stays 0.
REQ-036 SHALL verify reset mid-stream: reset pulsed while FULL -> out_valid=0 and out_data=0 immediately; the first scan grant after release is ch0.
